// File: rtl/pll_reset_sequencer.sv
// PLL lock supervisor: synchronizes the PLL locked flags, waits for a stable lock window,
// releases domain resets in order and recovers from lock faults with a bounded retry budget.
module pll_reset_sequencer #(
    parameter int N_PLL         = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int GAP_CYCLES    = 16,
    parameter int ARESET_CYCLES = 8,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int MAX_RETRIES   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_PLL-1:0] locked,
    output logic [N_PLL-1:0] rst_out_n,
    output logic             pll_areset,
    output logic             ready,
    output logic             lock_lost,
    output logic             fail,
    output logic [2:0]       state
);

    localparam int SYNC_N     = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int REL_CYCLES = N_PLL * GAP_CYCLES;

    localparam int SW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam int TW = (LOCK_TIMEOUT  < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = (REL_CYCLES    < 1) ? 1 : $clog2(REL_CYCLES + 1);
    localparam int AW = (ARESET_CYCLES < 1) ? 1 : $clog2(ARESET_CYCLES + 1);
    localparam int CW = (MAX_RETRIES   < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LIMIT  = TW'(LOCK_TIMEOUT);
    localparam logic [RW-1:0] REL_LAST  = RW'(REL_CYCLES - 1);
    localparam logic [AW-1:0] AR_LAST   = AW'(ARESET_CYCLES - 1);
    localparam logic [CW-1:0] RETRY_MAX = CW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4,
        DEAD      = 3'd5
    } state_t;

    state_t                  state_reg, state_next;
    logic [SYNC_N*N_PLL-1:0] sync_reg;
    logic                    all_lk;

    logic [SW-1:0] stab_cnt_reg, stab_cnt_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next, to_cnt_inc;
    logic [RW-1:0] rel_cnt_reg, rel_cnt_next;
    logic [AW-1:0] ar_cnt_reg, ar_cnt_next;
    logic [CW-1:0] retry_cnt_reg, retry_cnt_next;
    logic          timeout;
    logic          fault_req;

    logic [N_PLL-1:0] rel_mask;
    logic [N_PLL-1:0] rst_out_n_reg, rst_out_n_next;
    logic             pll_areset_reg, pll_areset_next;
    logic             ready_reg, ready_next;
    logic             lock_lost_reg, lock_lost_next;
    logic             fail_reg, fail_next;

    // Shift register of SYNC_N stages, each stage N_PLL bits wide; newest sample at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[(SYNC_N-1)*N_PLL-1:0], locked};
        end
    end

    assign all_lk = &sync_reg[SYNC_N*N_PLL-1 -: N_PLL];

    // Domain k is released once the release counter has covered k gaps.
    genvar gi;
    generate
        for (gi = 0; gi < N_PLL; gi++) begin : g_release
            if (gi == 0) begin : g_first
                assign rel_mask[gi] = 1'b1;
            end else begin : g_later
                localparam logic [RW-1:0] THR = RW'(gi * GAP_CYCLES);
                assign rel_mask[gi] = (rel_cnt_next >= THR);
            end
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        stab_cnt_next  = stab_cnt_reg;
        to_cnt_next    = to_cnt_reg;
        rel_cnt_next   = rel_cnt_reg;
        ar_cnt_next    = ar_cnt_reg;
        retry_cnt_next = retry_cnt_reg;
        lock_lost_next = lock_lost_reg;
        fault_req      = 1'b0;
        to_cnt_inc     = to_cnt_reg + TW'(1);
        timeout        = (to_cnt_inc == TO_LIMIT);

        case (state_reg)
            WAIT_LOCK: begin
                to_cnt_next = to_cnt_inc;
                if (timeout) begin
                    fault_req = 1'b1;
                end else if (all_lk) begin
                    state_next    = STABLE;
                    stab_cnt_next = '0;
                end
            end
            STABLE: begin
                // Timeout outranks completion; a dropout keeps the attempt's timeout running.
                to_cnt_next = to_cnt_inc;
                if (timeout) begin
                    fault_req = 1'b1;
                end else if (!all_lk) begin
                    state_next = WAIT_LOCK;
                end else if (stab_cnt_reg == STAB_LAST) begin
                    state_next   = RELEASE;
                    rel_cnt_next = '0;
                end else begin
                    stab_cnt_next = stab_cnt_reg + SW'(1);
                end
            end
            RELEASE: begin
                if (!all_lk) begin
                    fault_req      = 1'b1;
                    lock_lost_next = 1'b1;
                end else if (rel_cnt_reg == REL_LAST) begin
                    state_next     = RUN;
                    retry_cnt_next = '0;
                end else begin
                    rel_cnt_next = rel_cnt_reg + RW'(1);
                end
            end
            RUN: begin
                if (!all_lk) begin
                    fault_req      = 1'b1;
                    lock_lost_next = 1'b1;
                end
            end
            FAULT: begin
                if (ar_cnt_reg == AR_LAST) begin
                    state_next     = WAIT_LOCK;
                    retry_cnt_next = retry_cnt_reg + CW'(1);
                    to_cnt_next    = '0;
                end else begin
                    ar_cnt_next = ar_cnt_reg + AW'(1);
                end
            end
            DEAD: begin
            end
            default: begin
                state_next = WAIT_LOCK;
            end
        endcase

        if (fault_req) begin
            ar_cnt_next = '0;
            if (retry_cnt_reg < RETRY_MAX) begin
                state_next = FAULT;
            end else begin
                state_next = DEAD;
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        rst_out_n_next  = '0;
        pll_areset_next = 1'b0;
        ready_next      = 1'b0;
        fail_next       = fail_reg;
        case (state_next)
            RELEASE: rst_out_n_next = rel_mask;
            RUN: begin
                rst_out_n_next = '1;
                ready_next     = 1'b1;
            end
            FAULT:   pll_areset_next = 1'b1;
            DEAD:    fail_next       = 1'b1;
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= WAIT_LOCK;
            stab_cnt_reg   <= '0;
            to_cnt_reg     <= '0;
            rel_cnt_reg    <= '0;
            ar_cnt_reg     <= '0;
            retry_cnt_reg  <= '0;
            rst_out_n_reg  <= '0;
            pll_areset_reg <= 1'b0;
            ready_reg      <= 1'b0;
            lock_lost_reg  <= 1'b0;
            fail_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            stab_cnt_reg   <= stab_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            rel_cnt_reg    <= rel_cnt_next;
            ar_cnt_reg     <= ar_cnt_next;
            retry_cnt_reg  <= retry_cnt_next;
            rst_out_n_reg  <= rst_out_n_next;
            pll_areset_reg <= pll_areset_next;
            ready_reg      <= ready_next;
            lock_lost_reg  <= lock_lost_next;
            fail_reg       <= fail_next;
        end
    end

    assign rst_out_n  = rst_out_n_reg;
    assign pll_areset = pll_areset_reg;
    assign ready      = ready_reg;
    assign lock_lost  = lock_lost_reg;
    assign fail       = fail_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus randomized lock dropouts, checked
// every cycle against a timestamp-based model of the supervisor's rules.
module tb_pll_reset_sequencer;

    localparam int N    = 3;
    localparam int SYNC = 2;
    localparam int STAB = 8;
    localparam int GAP  = 4;
    localparam int ARC  = 3;
    localparam int TMO  = 50;
    localparam int MAXR = 2;

    localparam int P_WAIT   = 0;
    localparam int P_STABLE = 1;
    localparam int P_REL    = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;
    localparam int P_DEAD   = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] locked = '0;
    logic [N-1:0] rst_out_n;
    logic         pll_areset;
    logic         ready;
    logic         lock_lost;
    logic         fail;
    logic [2:0]   state;

    pll_reset_sequencer #(
        .N_PLL        (N),
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STAB),
        .GAP_CYCLES   (GAP),
        .ARESET_CYCLES(ARC),
        .LOCK_TIMEOUT (TMO),
        .MAX_RETRIES  (MAXR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .locked    (locked),
        .rst_out_n (rst_out_n),
        .pll_areset(pll_areset),
        .ready     (ready),
        .lock_lost (lock_lost),
        .fail      (fail),
        .state     (state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: edge count since reset plus the timestamp at which each phase began.
    int now, attempt_t0, stable_t0, rel_t0, fault_t0, phase, retries;
    bit m_lost;
    bit hist[$];

    // Observed event timestamps.
    int           rise_at[N];
    int           ready_at, dead_at, areset_cycles, areset_pulses;
    logic [N-1:0] prev_rst;
    logic         prev_ready, prev_areset;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp_v, now);
        end
    endtask

    function automatic void clear_marks();
        for (int k = 0; k < N; k++) rise_at[k] = -1;
        ready_at      = -1;
        dead_at       = -1;
        areset_cycles = 0;
        areset_pulses = 0;
    endfunction

    function automatic void model_clear();
        now        = 0;
        attempt_t0 = 0;
        stable_t0  = 0;
        rel_t0     = 0;
        fault_t0   = 0;
        phase      = P_WAIT;
        retries    = 0;
        m_lost     = 1'b0;
        hist.delete();
        for (int i = 0; i <= SYNC; i++) hist.push_back(1'b0);
        prev_rst    = '0;
        prev_ready  = 1'b0;
        prev_areset = 1'b0;
        clear_marks();
    endfunction

    function automatic void go_fault(input bit lost);
        if (lost) m_lost = 1'b1;
        if (retries < MAXR) begin
            phase    = P_FAULT;
            fault_t0 = now;
        end else begin
            phase = P_DEAD;
        end
    endfunction

    function automatic void model_edge(input bit lk);
        now++;
        case (phase)
            P_WAIT, P_STABLE: begin
                if (now - attempt_t0 == TMO) go_fault(1'b0);
                else if (phase == P_WAIT) begin
                    if (lk) begin
                        phase     = P_STABLE;
                        stable_t0 = now;
                    end
                end else if (!lk) phase = P_WAIT;
                else if (now - stable_t0 == STAB) begin
                    phase  = P_REL;
                    rel_t0 = now;
                end
            end
            P_REL: begin
                if (!lk) go_fault(1'b1);
                else if (now - rel_t0 == N * GAP) begin
                    phase   = P_RUN;
                    retries = 0;
                end
            end
            P_RUN: if (!lk) go_fault(1'b1);
            P_FAULT: begin
                if (now - fault_t0 == ARC) begin
                    phase      = P_WAIT;
                    retries    = retries + 1;
                    attempt_t0 = now;
                end
            end
            default: begin
            end
        endcase
    endfunction

    function automatic logic [9:0] expected();
        logic [N-1:0] r;
        logic [2:0]   st;
        r = '0;
        if (phase == P_REL)
            for (int k = 0; k < N; k++) if (now - rel_t0 >= k * GAP) r[k] = 1'b1;
        if (phase == P_RUN) r = '1;
        st = 3'(phase);
        return {st, r, phase == P_FAULT, phase == P_RUN, m_lost, phase == P_DEAD};
    endfunction

    function automatic void observe();
        for (int k = 0; k < N; k++)
            if (rst_out_n[k] && !prev_rst[k] && rise_at[k] < 0) rise_at[k] = now;
        if (ready && !prev_ready && ready_at < 0) ready_at = now;
        if (pll_areset) areset_cycles++;
        if (pll_areset && !prev_areset) areset_pulses++;
        if (state === 3'd5 && dead_at < 0) dead_at = now;
        prev_rst    = rst_out_n;
        prev_ready  = ready;
        prev_areset = pll_areset;
    endfunction

    // One clock cycle: record the driven input, advance model and DUT, compare all outputs.
    task automatic tick(input string tag);
        hist.push_back(&locked);
        hist.delete(0);
        @(posedge clk);
        model_edge(hist[0]);
        #1;
        observe();
        check(tag, {state, rst_out_n, pll_areset, ready, lock_lost, fail}, expected());
    endtask

    // Reset asserted mid-cycle; outputs must clear before the next clock edge.
    task automatic apply_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check(tag, {state, rst_out_n, pll_areset, ready, lock_lost, fail}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_clear();
    endtask

    int d, t_drop, relock, gbit, hold, b;

    initial begin
        model_clear();

        // Clean start: locked all high after cycle 10.
        locked = '0;
        apply_reset("reset_state");
        repeat (10) tick("clean_wait");
        locked = '1;
        repeat (30) tick("clean");
        check("clean_rise0", rise_at[0], 21);
        check("clean_rise1", rise_at[1], 25);
        check("clean_rise2", rise_at[2], 29);
        check("clean_ready", ready_at, 33);
        check("clean_no_areset", areset_pulses, 0);
        check("clean_lock_lost", lock_lost, 0);

        // Loss of lock while running, then re-lock and full re-release.
        d = $urandom_range(1, 8);
        repeat (d) tick("run_hold");
        locked[2] = 1'b0;
        t_drop = now;
        clear_marks();
        repeat (2) tick("loss_latency");
        check("loss_still_released", rst_out_n, 3'b111);
        tick("loss_detect");
        check("loss_rst_low", rst_out_n, 3'b000);
        check("loss_ready_low", ready, 0);
        check("loss_flag", lock_lost, 1);
        relock = $urandom_range(10, 20);
        repeat (relock - 3) tick("loss_fault");
        check("loss_areset_width", areset_cycles, ARC);
        locked = '1;
        clear_marks();
        repeat (30) tick("relock");
        check("relock_rise0", rise_at[0], t_drop + relock + 11);
        check("relock_rise2", rise_at[2], t_drop + relock + 19);
        check("relock_ready", ready_at, t_drop + relock + 23);
        check("relock_flag_sticky", lock_lost, 1);

        // One-cycle glitch on a random PLL while the stable count is at 5.
        locked = '0;
        apply_reset("glitch_reset");
        repeat (10) tick("glitch_wait");
        locked = '1;
        repeat (6) tick("glitch_stable");
        gbit = $urandom_range(0, N - 1);
        locked[gbit] = 1'b0;
        tick("glitch_low");
        locked = '1;
        repeat (30) tick("glitch_recover");
        check("glitch_rise0", rise_at[0], 28);
        check("glitch_rise1", rise_at[1], 32);
        check("glitch_rise2", rise_at[2], 36);
        check("glitch_ready", ready_at, 40);
        check("glitch_no_fault", areset_pulses, 0);

        // Lock drops one cycle after domain 1 is released: fault wins over the last release.
        locked = '0;
        apply_reset("midrel_reset");
        repeat (10) tick("midrel_wait");
        locked = '1;
        repeat (16) tick("midrel_stable");
        locked[0] = 1'b0;
        repeat (3) tick("midrel_detect");
        check("midrel_state", state, 3'd4);
        check("midrel_rst_low", rst_out_n, 3'b000);
        repeat (20) tick("midrel_after");
        check("midrel_rise1", rise_at[1], 25);
        check("midrel_no_rise2", rise_at[2], -1);
        check("midrel_flag", lock_lost, 1);

        // One PLL never locks: two retries then DEAD.
        locked = 3'b011;
        apply_reset("dead_reset");
        repeat (170) tick("dead_run");
        check("dead_pulses", areset_pulses, 2);
        check("dead_areset_cycles", areset_cycles, 2 * ARC);
        check("dead_entry", dead_at, 3 * TMO + 2 * ARC);
        check("dead_lock_lost", lock_lost, 0);
        locked = '1;
        repeat (20) tick("dead_hold");
        check("dead_state", state, 3'd5);
        check("dead_fail", fail, 1);

        // Reach RUN with lock_lost set, then pulse rst_n mid-cycle.
        locked = '1;
        apply_reset("async_prep_reset");
        repeat (25) tick("async_run");
        b = $urandom_range(0, N - 1);
        locked[b] = 1'b0;
        repeat (2) tick("async_drop");
        locked = '1;
        repeat (40) tick("async_relock");
        check("async_pre_ready", ready, 1);
        check("async_pre_flag", lock_lost, 1);
        apply_reset("async_reset_run");
        repeat (5) tick("async_after");
        check("async_flag_cleared", lock_lost, 0);

        // Randomized dropouts of random length on random PLLs.
        for (int seg = 0; seg < 3; seg++) begin
            locked = '0;
            apply_reset("soak_reset");
            hold = 0;
            for (int c = 0; c < 300; c++) begin
                if (hold > 0) begin
                    hold--;
                end else if ($urandom_range(0, 24) == 0) begin
                    b = $urandom_range(0, N - 1);
                    locked = '1;
                    locked[b] = 1'b0;
                    hold = $urandom_range(1, 5);
                end else begin
                    locked = '1;
                end
                tick("soak");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Supervisor for the three board PLLs (sys, i2s, sdram), clocked from the 12 MHz reference. It synchronizes every PLL `locked` flag and requires all of them to hold continuously for a stability window. It then releases the per-domain resets in a fixed order, one gap apart. On loss of lock or lock timeout it re-asserts all domain resets, pulses the PLL `areset`, and retries a bounded number of times. It sits between the PLL instances and the reset inputs of every clock domain; each domain re-synchronizes its `rst_out_n` bit locally.

## Interface
- `N_PLL`, default 3: number of supervised PLLs and domain resets. Bit 0 is released first.
- `SYNC_STAGES`, default 2: flip-flop stages on each `locked` input (minimum 2).
- `STABLE_CYCLES`, default 1024: number of consecutive cycles with all PLLs locked required before release.
- `GAP_CYCLES`, default 16: cycles between successive domain reset releases.
- `ARESET_CYCLES`, default 8: width of the `pll_areset` pulse.
- `LOCK_TIMEOUT`, default 65535: maximum number of cycles spent in WAIT_LOCK plus STABLE per attempt.
- `MAX_RETRIES`, default 3: number of FAULT recoveries allowed before DEAD.
- `clk` input 1: 12 MHz reference clock; single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `locked` input N_PLL: raw PLL lock flags, asynchronous to `clk`.
- `rst_out_n` output N_PLL: active-low domain resets. Reset value all 0.
- `pll_areset` output 1: active-high PLL reset, drives all PLLs. Reset value 0.
- `ready` output 1: all domains released and running. Reset value 0.
- `lock_lost` output 1: sticky flag, set on any loss of lock after release. Reset value 0.
- `fail` output 1: sticky flag, set when retries are exhausted. Reset value 0.
- `state` output 3: FSM state encoding for debug. Reset value WAIT_LOCK = 0.

## Operation
- `all_lk` is the AND of the `locked` bits after the synchronizer. It is valid SYNC_STAGES cycles after the inputs settle.
- All outputs are registered. Counter widths are $clog2(max+1) of their respective limits.
- **WAIT_LOCK (0)**: `rst_out_n` = 0, `ready` = 0. If `all_lk` is high, clear the stability counter and go to STABLE.
- **STABLE (1)**: the stability counter increments every cycle.
  - If `all_lk` drops, go to WAIT_LOCK. The timeout counter is not cleared.
  - When the count reaches STABLE_CYCLES−1 with `all_lk` still high, go to RELEASE.
- **RELEASE (2)**:
  - `rst_out_n[0]` goes high on the first cycle in RELEASE.
  - `rst_out_n[k]` goes high k·GAP_CYCLES cycles later.
  - GAP_CYCLES cycles after `rst_out_n[N_PLL−1]` rises, go to RUN.
- **RUN (3)**: `ready` = 1 and the retry counter is cleared.
- **Timeout**: a timeout counter runs in WAIT_LOCK and STABLE. On reaching LOCK_TIMEOUT, go to FAULT. `lock_lost` is not set in this case.
- **Loss of lock**: if `all_lk` is low in RELEASE or RUN, go to FAULT and set `lock_lost`.
- **FAULT (4)**:
  - `rst_out_n` = 0, `ready` = 0, `pll_areset` = 1 for exactly ARESET_CYCLES cycles.
  - Then the retry counter increments, the timeout counter clears, and the FSM goes to WAIT_LOCK.
- **Retry limit**: FAULT is entered only if retries < MAX_RETRIES. Otherwise the FSM goes to DEAD.
- **DEAD (5)**: terminal. `fail` = 1, `rst_out_n` = 0, `pll_areset` = 0, `ready` = 0. Only `rst_n` exits DEAD.
- **Simultaneous events**:
  - Loss of lock on the same cycle as a RELEASE step: fault wins, and no further bits are released.
  - Timeout on the same cycle as the STABLE completion: timeout wins.
- **Reset mid-operation**: `rst_n` low immediately forces all outputs to their reset values, including clearing the sticky flags.

## Timing
- Input-to-state latency is SYNC_STAGES + 1 cycles.
- Domain resets assert one cycle after the fault is detected on `all_lk`. They assert together, with no ordering on assertion.
- First domain release is SYNC_STAGES + 1 + STABLE_CYCLES cycles after `locked` goes all-high.
- `ready` rises N_PLL·GAP_CYCLES cycles after `rst_out_n[0]`.
- `pll_areset` rises on the cycle FAULT is entered. It falls ARESET_CYCLES later, on the same edge as the transition to WAIT_LOCK.

## Test plan
All scenarios use STABLE_CYCLES=8, GAP_CYCLES=4, ARESET_CYCLES=3, LOCK_TIMEOUT=50, MAX_RETRIES=2, N_PLL=3, SYNC_STAGES=2.

- **Clean start**: `locked`=3'b111 at cycle 10.
  - `rst_out_n` bits rise at cycles 21, 25 and 29; `ready` rises at 33.
  - `pll_areset` never asserts; `lock_lost`=0.
- **Glitch during STABLE**: `locked[1]` low for 1 cycle at stable count 5.
  - FSM returns to WAIT_LOCK and the stability count restarts.
  - Release is delayed accordingly; no FAULT occurs.
- **Loss after RUN**: `locked[2]` drops while in RUN.
  - All `rst_out_n` are 0 three cycles later; `ready`=0; `lock_lost`=1.
  - `pll_areset` is high for 3 cycles.
  - After re-lock, the full release sequence repeats and `lock_lost` stays 1.
- **Timeout to DEAD**: `locked`=3'b011 held forever.
  - Three timeouts occur: FAULT, FAULT, then DEAD.
  - Exactly two `pll_areset` pulses; `fail`=1 permanently; `state`=5.
- **Mid-release fault**: `locked[0]` drops one cycle after `rst_out_n[1]` rises.
  - `rst_out_n[2]` never rises; FSM enters FAULT.
- **Async reset in RUN**: `rst_n` pulsed low mid-cycle.
  - All outputs return to their reset values before the next `clk` edge.
  - Sticky flags clear.
